md5_padder: RTL and testbench
=============================

# md5_padder

Upstream feeder for the MD5 hash core. Accepts an arbitrary-length message as a 32-bit word stream and emits 512-bit blocks padded per RFC 1321: a 0x80 marker, zero fill, and a 64-bit little-endian bit count. Its block output connects directly to the core's `msg_padded` / `msg_in_valid` / `ready` inputs. This removes host-side padding and lets software stream raw bytes.

## Interface

Parameters:
- `LEN_W`, default 64: width of the bit-length counter. Fixed at 64 for MD5 compliance.

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clr`, in, 1: synchronous soft clear. Same effect as reset.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: padder can accept a word.
- `in_data`, in, 32: message bytes. Stream byte 0 is `in_data[31:24]`.
- `in_last`, in, 1: this is the final word of the message.
- `in_nbytes`, in, 3: valid bytes (0..4) in the word, MSB-first. Sampled only with `in_last`; non-last words are always 4 bytes.
- `blk_valid`, out, 1: `blk_data` holds a complete block.
- `blk_ready`, in, 1: downstream accepts the block.
- `blk_data`, out, 512: the block. Block byte 0 is `blk_data[511:504]`.
- `blk_first`, out, 1: first block of the message.
- `blk_last`, out, 1: final (length-carrying) block.

## Operation

States: IDLE, FILL, EMIT, EXTRA, EMIT_X.

- **IDLE / FILL:** `in_ready`=1.
  - Each accepted word is written to buffer word `widx`, then `widx`++.
  - The bit counter `len` += 32, or += 8·`in_nbytes` on the last word. `len` wraps modulo 2^64.
- **Non-last word at `widx`=15:** go to EMIT with a data-only block; `blk_last`=0.
- **Last word** (byte position p = 4·`widx` + `in_nbytes`):
  - Write 0x80 at byte p when p < 64, and zero bytes p+1..63.
  - If p ≤ 55: write `len` little-endian into bytes 56..63 (`len[7:0]` at byte 56). Go to EMIT with `blk_last`=1.
  - Otherwise go to EMIT with `blk_last`=0 and set the pending-tail flag.
  - p = 64 (full final block): the data block is emitted unchanged. 0x80 moves to byte 0 of the tail block.
- **EMIT:** `blk_valid`=1 and `in_ready`=0. On `blk_valid`&`blk_ready`:
  - If the pending tail is set, go to EXTRA.
  - Else if `blk_last`, go to IDLE and clear `len`/`blk_first`.
  - Else go to FILL with `widx`=0.
- **EXTRA** (1 cycle): build a block of zeros, 0x80 at byte 0 only if p was 64, and `len` in bytes 56..63. Go to EMIT_X.
- **EMIT_X:** same as EMIT with `blk_last`=1, then go to IDLE.
- **`blk_first`:** 1 for the first block after IDLE; 0 for all later blocks of the message.
- **`clr` or `rst_n` low:** abort any operation and discard the partial message. `clr` wins over a simultaneous `in_valid`.
- **`in_nbytes` > 4 with `in_last`:** treated as 4.

## Timing

- Reset values: `in_ready`=0 during reset and 1 in IDLE afterwards. `blk_valid`=0, `blk_data`=0, `blk_first`=0, `blk_last`=0, `len`=0, `widx`=0.
- Word accepted at cycle N with `widx`=15 or `in_last` → `blk_valid` at N+1.
- Tail block: `blk_valid` is asserted 2 cycles after the preceding block is accepted. `blk_valid` is 0 during EXTRA.
- While `blk_valid`=1, `blk_data`/`blk_first`/`blk_last` are stable until accepted.
- At most one block in flight. No input is accepted while a block is pending.
- Sustained throughput: 16 words + 1 emit cycle per block when `blk_ready` is held at 1.

## Configuration

- `MD5_PADDER_BLKCNT_EN` defined:
  - Adds output `blk_count[31:0]`, which counts accepted blocks since reset or `clr`.
  - The counter wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure

- Shared package `md5_pkg`:
  - state enum;
  - `MD5_BLK_W`=512, `MD5_WORD_W`=32, `MD5_LEN_W`=64;
  - pad byte 8'h80;
  - length-field byte offset 56.
- One sub-module, `md5_pad_mask`: combinational builder. Given buffer, p, `len`, and a tail/fits select, it produces the 512-bit padded block.

## Test plan

- **"abc":** one word 32'h61626300, `in_nbytes`=3, `in_last`.
  - Expect `blk_data[511:480]`=32'h61626380 and `blk_data[63:56]`=8'h18; all other bits 0.
  - Expect `blk_first`=`blk_last`=1, one cycle after accept.
- **Empty message:** `in_nbytes`=0 with `in_last`. Expect `blk_data[511:504]`=8'h80, rest 0, `blk_last`=1.
- **56-byte message** (14 words, last with 4 bytes):
  - Block 1: data, byte 56 = 0x80, `blk_last`=0.
  - Block 2: all zero except byte 56 = 0xC0 and byte 57 = 0x01; `blk_first`=0, `blk_last`=1.
- **64-byte message:**
  - Block 1: pure data, `blk_last`=0.
  - Block 2: byte 0 = 0x80, byte 57 = 0x02, `blk_last`=1.
- **Backpressure:** hold `blk_ready`=0 for 5 cycles. `blk_data` must be stable and `in_ready`=0 throughout; exactly one handshake occurs on release.
- **Abort mid-message:**
  - Assert `rst_n`=0 after 7 words, then send "abc". The output must match the "abc" case.
  - Repeat with `clr`=1 coincident with an `in_valid` word; that word is dropped.

Source files
------------

// File: rtl/md5_pkg.sv
// md5_pkg: shared FSM type and constants for the MD5 block padder.
package md5_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_EXTRA,
        S_EMIT_X
    } state_t;

    localparam int MD5_BLK_W  = 512;
    localparam int MD5_WORD_W = 32;
    localparam int MD5_LEN_W  = 64;
    localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
    localparam int MD5_LEN_OFF = 56;

    function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/md5_pad_mask.sv
// md5_pad_mask: combinational builder of one padded block from buffered data, end byte p and bit length.
// tail selects the length-only block that follows a message whose end did not leave room for the length.
module md5_pad_mask
    import md5_pkg::*;
(
    input  logic [MD5_BLK_W-1:0] data,
    input  logic [6:0]           p,
    input  logic [MD5_LEN_W-1:0] len,
    input  logic                 tail,
    input  logic                 fits,
    output logic [MD5_BLK_W-1:0] blk
);

    logic [6:0] mark_pos;
    logic       mark_en;
    logic       len_en;

    // A tail block only carries the marker when the data block was completely full.
    assign mark_pos = tail ? 7'd0 : p;
    assign mark_en  = tail ? (p == 7'd64) : (p < 7'd64);
    assign len_en   = tail | fits;

    for (genvar i = 0; i < 64; i++) begin : g_byte
        logic [7:0] pad;
        assign pad = (!tail && 7'(i) < p) ? data[MD5_BLK_W-1-8*i -: 8] :
                     (mark_en && 7'(i) == mark_pos) ? MD5_PAD_BYTE : 8'h00;
        if (i >= MD5_LEN_OFF) begin : g_len
            assign blk[MD5_BLK_W-1-8*i -: 8] = len_en ? len[8*(i-MD5_LEN_OFF) +: 8] : pad;
        end else begin : g_pad
            assign blk[MD5_BLK_W-1-8*i -: 8] = pad;
        end
    end

endmodule

// File: rtl/md5_padder.sv
// md5_padder: packs a 32-bit message word stream into RFC 1321 padded 512-bit MD5 blocks.
// Define MD5_PADDER_BLKCNT_EN to add the blk_count output counting accepted blocks.
module md5_padder
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MD5_WORD_W-1:0] in_data,
    input  logic                  in_last,
    input  logic [2:0]            in_nbytes,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [MD5_BLK_W-1:0]  blk_data,
    output logic                  blk_first,
`ifdef MD5_PADDER_BLKCNT_EN
    output logic [31:0]           blk_count,
`endif
    output logic                  blk_last
);

    state_t               state, state_nxt;
    logic [MD5_BLK_W-1:0] msg_q, cur, mask_blk;
    logic [LEN_W-1:0]     len, len_nxt;
    logic [3:0]           widx;
    logic [2:0]           nb;
    logic [6:0]           p, p_q;
    logic                 tail_q, first_pend, accept, hs, fits, close, tail_sel;

    assign accept   = in_valid && in_ready && !clr;
    assign hs       = blk_valid && blk_ready;
    assign nb       = in_last ? clamp_nbytes(in_nbytes) : 3'd4;
    assign p        = {1'b0, widx, 2'b00} + {4'd0, nb};
    assign len_nxt  = len + LEN_W'({nb, 3'b000});
    assign fits     = in_last && p <= 7'(MD5_LEN_OFF - 1);
    assign close    = in_last || widx == 4'd15;
    assign tail_sel = state == S_EXTRA;

    // Incoming word merged into the buffer so the block can be built in the accept cycle.
    always_comb begin
        cur = msg_q;
        cur[{~widx, 5'b0} +: MD5_WORD_W] = in_data;
    end

    md5_pad_mask u_mask (
        .data (cur),
        .p    (tail_sel ? p_q : p),
        .len  (tail_sel ? len : len_nxt),
        .tail (tail_sel),
        .fits (fits),
        .blk  (mask_blk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= clr ? S_IDLE : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        case (state)
            S_IDLE, S_FILL: begin
                in_ready = rst_n;
                if (in_valid && !clr)
                    state_nxt = close ? S_EMIT : S_FILL;
            end
            S_EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready)
                    state_nxt = tail_q ? S_EXTRA : (blk_last ? S_IDLE : S_FILL);
            end
            S_EXTRA: state_nxt = S_EMIT_X;
            S_EMIT_X: begin
                blk_valid = 1'b1;
                if (blk_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q      <= '0;
            len        <= '0;
            widx       <= '0;
            p_q        <= '0;
            tail_q     <= 1'b0;
            first_pend <= 1'b1;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
        end else if (clr) begin
            msg_q      <= '0;
            len        <= '0;
            widx       <= '0;
            p_q        <= '0;
            tail_q     <= 1'b0;
            first_pend <= 1'b1;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
        end else begin
            if (accept) begin
                msg_q <= cur;
                len   <= len_nxt;
                widx  <= widx + 4'd1;
                if (close) begin
                    blk_data   <= mask_blk;
                    blk_first  <= first_pend;
                    blk_last   <= fits;
                    tail_q     <= in_last && !fits;
                    p_q        <= p;
                    first_pend <= 1'b0;
                end
            end
            if (tail_sel) begin
                blk_data  <= mask_blk;
                blk_first <= 1'b0;
                blk_last  <= 1'b1;
                tail_q    <= 1'b0;
            end
            if (hs)
                widx <= '0;
            if (hs && blk_last) begin
                len        <= '0;
                first_pend <= 1'b1;
            end
        end
    end

`ifdef MD5_PADDER_BLKCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blk_count <= '0;
        else
            blk_count <= clr ? '0 : blk_count + 32'(hs);
    end
`endif

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder: directed self-checking bench for md5_padder.
module tb_md5_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
`ifdef MD5_PADDER_BLKCNT_EN
    logic [31:0]  blk_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    md5_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
`ifdef MD5_PADDER_BLKCNT_EN
        .blk_count (blk_count),
`endif
        .blk_last  (blk_last)
    );

    function automatic logic [31:0] word(input int k);
        return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    endfunction

    function automatic logic [511:0] ramp(input int n);
        logic [511:0] b;
        b = '0;
        for (int j = 0; j < n; j++) b[511-8*j -: 8] = 8'(j);
        return b;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        in_data   = d;
        in_last   = last;
        in_nbytes = nb;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = 3'd0;
    endtask

    task automatic take();
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        checks++;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_valid got=%b want=0", blk_valid); end
        checks++;
        if (blk_data !== 512'd0) begin errors++; $display("FAIL rst_blk_data got=%h want=0", blk_data); end
        checks++;
        if ({blk_first, blk_last} !== 2'b00) begin errors++; $display("FAIL rst_first_last got=%b want=00", {blk_first, blk_last}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_abc(input string name);
        logic [511:0] exp;
        exp = '0;
        exp[511:480] = 32'h61626380;
        exp[63:56]   = 8'h18;
        send_word(32'h61626300, 1'b1, 3'd3);
        checks++;
        if (blk_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b want=1", name, blk_valid); end
        checks++;
        if (blk_data !== exp) begin errors++; $display("FAIL %s_data got=%h want=%h", name, blk_data, exp); end
        checks++;
        if ({blk_first, blk_last} !== 2'b11) begin errors++; $display("FAIL %s_first_last got=%b want=11", name, {blk_first, blk_last}); end
        take();
        checks++;
        if ({blk_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL %s_idle got=%b want=01", name, {blk_valid, in_ready}); end
    endtask

    task automatic test_empty();
        logic [511:0] exp;
        exp = '0;
        exp[511:504] = 8'h80;
        send_word(32'h0, 1'b1, 3'd0);
        checks++;
        if (blk_data !== exp) begin errors++; $display("FAIL empty_data got=%h want=%h", blk_data, exp); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b111) begin errors++; $display("FAIL empty_flags got=%b want=111", {blk_valid, blk_first, blk_last}); end
        take();
    endtask

    task automatic test_clamp();
        logic [511:0] exp;
        exp = '0;
        exp[511:480] = 32'h11223344;
        exp[479:472] = 8'h80;
        exp[63:56]   = 8'h20;
        send_word(32'h11223344, 1'b1, 3'd7);
        checks++;
        if (blk_data !== exp) begin errors++; $display("FAIL clamp_data got=%h want=%h", blk_data, exp); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b111) begin errors++; $display("FAIL clamp_flags got=%b want=111", {blk_valid, blk_first, blk_last}); end
        take();
    endtask

    task automatic test_56();
        logic [511:0] exp1, exp2;
        exp1 = ramp(56);
        exp1[63:56] = 8'h80;
        exp2 = '0;
        exp2[63:56] = 8'hC0;
        exp2[55:48] = 8'h01;
        for (int k = 0; k < 13; k++) send_word(word(k), 1'b0, 3'd0);
        send_word(word(13), 1'b1, 3'd4);
        checks++;
        if (blk_data !== exp1) begin errors++; $display("FAIL m56_blk1_data got=%h want=%h", blk_data, exp1); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b110) begin errors++; $display("FAIL m56_blk1_flags got=%b want=110", {blk_valid, blk_first, blk_last}); end
        take();
        checks++;
        if ({blk_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL m56_extra got=%b want=00", {blk_valid, in_ready}); end
        @(negedge clk);
        checks++;
        if (blk_data !== exp2) begin errors++; $display("FAIL m56_blk2_data got=%h want=%h", blk_data, exp2); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b101) begin errors++; $display("FAIL m56_blk2_flags got=%b want=101", {blk_valid, blk_first, blk_last}); end
        take();
        checks++;
        if ({blk_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL m56_idle got=%b want=01", {blk_valid, in_ready}); end
    endtask

    task automatic test_64();
        logic [511:0] exp1, exp2;
        exp1 = ramp(64);
        exp2 = '0;
        exp2[511:504] = 8'h80;
        exp2[55:48]   = 8'h02;
        for (int k = 0; k < 15; k++) send_word(word(k), 1'b0, 3'd0);
        send_word(word(15), 1'b1, 3'd4);
        checks++;
        if (blk_data !== exp1) begin errors++; $display("FAIL m64_blk1_data got=%h want=%h", blk_data, exp1); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b110) begin errors++; $display("FAIL m64_blk1_flags got=%b want=110", {blk_valid, blk_first, blk_last}); end
        take();
        checks++;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL m64_extra got=%b want=0", blk_valid); end
        @(negedge clk);
        checks++;
        if (blk_data !== exp2) begin errors++; $display("FAIL m64_blk2_data got=%h want=%h", blk_data, exp2); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b101) begin errors++; $display("FAIL m64_blk2_flags got=%b want=101", {blk_valid, blk_first, blk_last}); end
        take();
    endtask

    task automatic test_backpressure();
        logic [511:0] exp1, exp2;
        exp1 = ramp(64);
        exp2 = '0;
        exp2[511:480] = 32'hA0A1A2A3;
        exp2[479:472] = 8'h80;
        exp2[63:56]   = 8'h20;
        exp2[55:48]   = 8'h02;
        for (int k = 0; k < 16; k++) send_word(word(k), 1'b0, 3'd0);
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b110) begin errors++; $display("FAIL bp_blk1_flags got=%b want=110", {blk_valid, blk_first, blk_last}); end
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (blk_data !== exp1) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", c, blk_data, exp1); end
            checks++;
            if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, blk_valid); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b want=0", c, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();
        checks++;
        if ({blk_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b want=01", {blk_valid, in_ready}); end
        send_word(32'hA0A1A2A3, 1'b1, 3'd4);
        checks++;
        if (blk_data !== exp2) begin errors++; $display("FAIL bp_blk2_data got=%h want=%h", blk_data, exp2); end
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b101) begin errors++; $display("FAIL bp_blk2_flags got=%b want=101", {blk_valid, blk_first, blk_last}); end
        take();
    endtask

    task automatic test_abort_rst();
        for (int k = 0; k < 7; k++) send_word(word(k), 1'b0, 3'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, blk_valid} !== 2'b00) begin errors++; $display("FAIL abort_rst_outputs got=%b want=00", {in_ready, blk_valid}); end
        rst_n = 1'b1;
        @(negedge clk);
        test_abc("abc_after_rst");
    endtask

    task automatic test_abort_clr();
        for (int k = 0; k < 7; k++) send_word(word(k), 1'b0, 3'd0);
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFFFFFF;
        in_last   = 1'b1;
        in_nbytes = 3'd4;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if ({blk_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL abort_clr_drop got=%b want=01", {blk_valid, in_ready}); end
        test_abc("abc_after_clr");
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_empty();
        test_clamp();
        test_56();
        test_64();
        test_backpressure();
        test_abort_rst();
        test_abort_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
